// File: rtl/motor_cmd_sequencer_if.sv
// Handshake bundle between the waiter FSM side and the motor command sequencer.
interface motor_cmd_sequencer_if #(
  parameter int STATE_W = 4,
  parameter int NUM_CH  = 5
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic               en_i;
  logic [STATE_W-1:0] direction_i;
  logic [NUM_CH-1:0]  ch_rst_o;
  logic [CW-1:0]      active_ch_o;
  logic               cmd_change_o;

  modport master (output en_i, direction_i, input ch_rst_o, active_ch_o, cmd_change_o);
  modport slave  (input en_i, direction_i, output ch_rst_o, active_ch_o, cmd_change_o);
endinterface

// File: rtl/motor_cmd_sequencer.sv
// Debounces the FSM direction code, maps it to a controller channel and issues
// periodic one-hot reset pulses on that channel.
module motor_cmd_sequencer #(
  parameter int STATE_W    = 4,
  parameter int NUM_CH     = 5,
  parameter int PERIOD     = 4194304,
  parameter int PULSE_W    = 1,
  parameter int SETTLE_CYC = 4,
  parameter int STOP_CH    = 2,
  parameter logic [3*(2**STATE_W)-1:0] CH_MAP = {
    3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0,
    3'd1, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3, 3'd0, 3'd2}
) (
  input logic clk,
  input logic rst_n,
  motor_cmd_sequencer_if.slave bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int WW = $clog2(PULSE_W + 1);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [WW-1:0] W_LAST = WW'(PULSE_W - 1);

  typedef enum logic [1:0] {OFF, SETTLE, PULSE, WAIT} state_e;

  state_e             state_q;
  logic [STATE_W-1:0] cand_q, dir_q;
  logic               cand_vld_q, first_q, acc_q;
  logic [SW-1:0]      settle_cnt_q;
  logic [WW-1:0]      pulse_cnt_q;
  logic [PW-1:0]      period_cnt_q;
  logic [NUM_CH-1:0]  ch_rst_q;
  logic [CW-1:0]      active_ch_q;
  logic               cmd_change_q;

  logic [STATE_W-1:0] dir;
  logic               match, settle_done;

  function automatic logic [CW-1:0] sel_ch(input logic [STATE_W-1:0] d);
    logic [2:0] f;
    f = CH_MAP[3*int'(d) +: 3];
    return (int'(f) >= NUM_CH) ? CW'(STOP_CH) : CW'(f);
  endfunction

  assign dir = bus.direction_i;
  // Right after reset the candidate is taken to be whatever direction is present.
  assign match       = !cand_vld_q || (dir == cand_q);
  assign settle_done = (int'(settle_cnt_q) + 1) >= (SETTLE_CYC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SETTLE;
      cand_q       <= '0;
      cand_vld_q   <= 1'b0;
      first_q      <= 1'b1;
      acc_q        <= 1'b0;
      settle_cnt_q <= '0;
      pulse_cnt_q  <= '0;
      period_cnt_q <= '0;
      dir_q        <= '0;
      ch_rst_q     <= '0;
      active_ch_q  <= CW'(STOP_CH);
      cmd_change_q <= 1'b0;
    end else begin
      cmd_change_q <= 1'b0;
      if (!bus.en_i) begin
        state_q      <= OFF;
        ch_rst_q     <= '0;
        acc_q        <= 1'b0;
        period_cnt_q <= '0;
      end else begin
        case (state_q)
          OFF: begin
            state_q      <= SETTLE;
            cand_q       <= dir;
            cand_vld_q   <= 1'b1;
            settle_cnt_q <= '0;
            first_q      <= 1'b1;
          end
          SETTLE: begin
            if (acc_q) begin
              // Accept cycle (cmd_change high) is done; pulse begins now.
              acc_q        <= 1'b0;
              state_q      <= PULSE;
              ch_rst_q     <= {{(NUM_CH-1){1'b0}}, 1'b1} << active_ch_q;
              pulse_cnt_q  <= '0;
              period_cnt_q <= '0;
            end else begin
              cand_q     <= dir;
              cand_vld_q <= 1'b1;
              if (!match) begin
                settle_cnt_q <= '0;
              end else if (settle_done) begin
                settle_cnt_q <= S_LAST;
                dir_q        <= dir;
                active_ch_q  <= sel_ch(dir);
                cmd_change_q <= first_q || (dir != dir_q);
                first_q      <= 1'b0;
                acc_q        <= 1'b1;
              end else begin
                settle_cnt_q <= settle_cnt_q + 1'b1;
              end
            end
          end
          PULSE: begin
            period_cnt_q <= period_cnt_q + 1'b1;
            if (pulse_cnt_q == W_LAST) begin
              ch_rst_q <= '0;
              if (dir != dir_q) begin
                state_q      <= SETTLE;
                cand_q       <= dir;
                settle_cnt_q <= '0;
              end else begin
                state_q <= WAIT;
              end
            end else begin
              pulse_cnt_q <= pulse_cnt_q + 1'b1;
            end
          end
          WAIT: begin
            if (dir != dir_q) begin
              state_q      <= SETTLE;
              cand_q       <= dir;
              settle_cnt_q <= '0;
            end else if (period_cnt_q == P_LAST) begin
              state_q      <= PULSE;
              ch_rst_q     <= {{(NUM_CH-1){1'b0}}, 1'b1} << active_ch_q;
              pulse_cnt_q  <= '0;
              period_cnt_q <= '0;
            end else begin
              period_cnt_q <= period_cnt_q + 1'b1;
            end
          end
          default: state_q <= OFF;
        endcase
      end
    end
  end

  assign bus.ch_rst_o     = ch_rst_q;
  assign bus.active_ch_o  = active_ch_q;
  assign bus.cmd_change_o = cmd_change_q;
endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench: two sequencers (default map, and a map with an out-of-range entry).
module tb_motor_cmd_sequencer;
  logic clk, rst_n;
  int   checks = 0, failures = 0, cyc = 0;
  int   ch_hi [5];
  int   cc_cnt = 0, onehot_err = 0;

  motor_cmd_sequencer_if #(.STATE_W(4), .NUM_CH(5)) bus ();
  motor_cmd_sequencer_if #(.STATE_W(4), .NUM_CH(5)) bus2 ();

  motor_cmd_sequencer #(.PERIOD(16), .PULSE_W(2), .SETTLE_CYC(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  // State 1 points at channel 7, which does not exist.
  motor_cmd_sequencer #(.PERIOD(16), .PULSE_W(2), .SETTLE_CYC(3),
    .CH_MAP({3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0,
             3'd1, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3, 3'd7, 3'd2})) u_dut7 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n) begin
    for (int i = 0; i < 5; i++) if (bus.ch_rst_o[i]) ch_hi[i]++;
    if (bus.cmd_change_o) cc_cnt++;
    if ($countones(bus.ch_rst_o) > 1 || $countones(bus2.ch_rst_o) > 1) onehot_err++;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) ch_hi[i] = 0;
    rst_n = 1'b0;
    bus.en_i = 1'b1;  bus.direction_i = 4'd0;
    bus2.en_i = 1'b1; bus2.direction_i = 4'd3;
    repeat (3) tick();
    chk("rst_ch_rst", int'(bus.ch_rst_o), 0);
    chk("rst_active", int'(bus.active_ch_o), 2);
    chk("rst_cmdchg", int'(bus.cmd_change_o), 0);
    rst_n = 1'b1;
    cyc = 0;

    // 1: stop pulses after reset
    goto(1);  chk("t1_e1_ch", int'(bus.ch_rst_o), 0);
    goto(2);  chk("t1_cc", int'(bus.cmd_change_o), 1);
              chk("t1_active", int'(bus.active_ch_o), 2);
              chk("t1_e2_ch", int'(bus.ch_rst_o), 0);
    goto(3);  chk("t1_e3_ch", int'(bus.ch_rst_o), 5'b00100);
              chk("t1_cc_off", int'(bus.cmd_change_o), 0);
              chk("m_ch", int'(bus2.ch_rst_o), 5'b00001);
              chk("m_active0", int'(bus2.active_ch_o), 0);
    goto(4);  chk("t1_e4_ch", int'(bus.ch_rst_o), 5'b00100);
    goto(5);  chk("t1_e5_ch", int'(bus.ch_rst_o), 0);
    bus2.direction_i = 4'd1;
    goto(8);  chk("m_active7", int'(bus2.active_ch_o), 2);
              chk("m_cc", int'(bus2.cmd_change_o), 1);
    goto(9);  chk("m_ch_stop", int'(bus2.ch_rst_o), 5'b00100);
    goto(18); chk("t1_e18_ch", int'(bus.ch_rst_o), 0);
    goto(19); chk("t1_e19_ch", int'(bus.ch_rst_o), 5'b00100);
    goto(21); chk("t1_e21_ch", int'(bus.ch_rst_o), 0);
              chk("t1_stop_cnt", ch_hi[2], 4);
              chk("t1_cc_cnt", cc_cnt, 1);

    // 2: 0 -> 1 (fwd)
    bus.direction_i = 4'd1;
    goto(23); chk("t2_e23_cc", int'(bus.cmd_change_o), 0);
    goto(24); chk("t2_cc", int'(bus.cmd_change_o), 1);
              chk("t2_active", int'(bus.active_ch_o), 0);
              chk("t2_e24_ch", int'(bus.ch_rst_o), 0);
    goto(25); chk("t2_e25_ch", int'(bus.ch_rst_o), 5'b00001);
    goto(27); chk("t2_e27_ch", int'(bus.ch_rst_o), 0);
    goto(40); chk("t2_e40_ch", int'(bus.ch_rst_o), 0);
    goto(41); chk("t2_e41_ch", int'(bus.ch_rst_o), 5'b00001);
    goto(43); chk("t2_fwd_cnt", ch_hi[0], 4);
              chk("t2_stop_cnt", ch_hi[2], 4);
              chk("t2_cc_cnt", cc_cnt, 2);

    // 3: two-cycle glitch to 5 while waiting
    goto(45); bus.direction_i = 4'd5;
    goto(47); bus.direction_i = 4'd1;
              chk("t3_e47_active", int'(bus.active_ch_o), 0);
    goto(50); chk("t3_e50_cc", int'(bus.cmd_change_o), 0);
              chk("t3_e50_ch", int'(bus.ch_rst_o), 0);
    goto(51); chk("t3_e51_ch", int'(bus.ch_rst_o), 5'b00001);
    goto(53); chk("t3_rev_cnt", ch_hi[1], 0);
              chk("t3_fwd_cnt", ch_hi[0], 6);
              chk("t3_cc_cnt", cc_cnt, 2);

    // 4: 1 -> 6 during a pulse
    goto(66); chk("t4_e66_ch", int'(bus.ch_rst_o), 0);
    goto(67); chk("t4_e67_ch", int'(bus.ch_rst_o), 5'b00001);
    bus.direction_i = 4'd6;
    goto(68); chk("t4_e68_ch", int'(bus.ch_rst_o), 5'b00001);
    goto(69); chk("t4_e69_ch", int'(bus.ch_rst_o), 0);
    goto(71); chk("t4_cc", int'(bus.cmd_change_o), 1);
              chk("t4_active", int'(bus.active_ch_o), 4);
    goto(72); chk("t4_e72_ch", int'(bus.ch_rst_o), 5'b10000);
    goto(73); chk("t4_e73_ch", int'(bus.ch_rst_o), 5'b10000);
    goto(74); chk("t4_e74_ch", int'(bus.ch_rst_o), 0);

    // 5: unmapped states 9 and 15
    bus.direction_i = 4'd9;
    goto(77); chk("t5_9_cc", int'(bus.cmd_change_o), 1);
              chk("t5_9_active", int'(bus.active_ch_o), 2);
    goto(78); chk("t5_9_ch", int'(bus.ch_rst_o), 5'b00100);
    goto(80); bus.direction_i = 4'd15;
    goto(83); chk("t5_15_cc", int'(bus.cmd_change_o), 1);
              chk("t5_15_active", int'(bus.active_ch_o), 2);
    goto(84); chk("t5_15_ch", int'(bus.ch_rst_o), 5'b00100);

    // 6: enable drop mid-pulse, re-enable, then async reset mid-pulse
    goto(100); chk("t6_e100_ch", int'(bus.ch_rst_o), 5'b00100);
    bus.en_i = 1'b0;
    goto(101); chk("t6_off_ch", int'(bus.ch_rst_o), 0);
               chk("t6_off_active", int'(bus.active_ch_o), 2);
    goto(103); chk("t6_e103_ch", int'(bus.ch_rst_o), 0);
    bus.en_i = 1'b1;
    goto(106); chk("t6_cc", int'(bus.cmd_change_o), 1);
               chk("t6_e106_ch", int'(bus.ch_rst_o), 0);
    goto(107); chk("t6_e107_ch", int'(bus.ch_rst_o), 5'b00100);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_ch", int'(bus.ch_rst_o), 0);
    chk("t6_arst_cc", int'(bus.cmd_change_o), 0);
    chk("t6_arst_active", int'(bus.active_ch_o), 2);
    chk("t6_arst_ch2", int'(bus2.ch_rst_o), 0);
    chk("onehot", onehot_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (edge %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
